// File: rtl/conv_output_collector.sv
// conv_output_collector: captures one strided conv output frame, then drains it over valid/ready.
// Define COLLECTOR_TRANSPOSE_EN to drain column-major instead of row-major.
module conv_output_collector #(
    parameter int IMG_Width  = 5,
    parameter int IMG_Height = 5,
    parameter int Datawidth  = 16,
    parameter int Stride     = 1
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [Datawidth-1:0] In,
    input  logic                 Valid_IN,
    input  logic                 Ready_IN,
    output logic [Datawidth-1:0] Out,
    output logic                 Valid_OUT,
    output logic                 Frame_Done,
    output logic                 Busy,
    output logic                 Overflow
);
    localparam int OUT_W = (IMG_Width + Stride - 1) / Stride;
    localparam int OUT_H = (IMG_Height + Stride - 1) / Stride;
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t               state;
    logic [Datawidth-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_addr, rd_cnt, rd_addr;
    logic                 take, last_wr, xfer, last_rd;

    assign take    = Valid_IN && state == FILL;
    assign last_wr = wr_addr == AW'(DEPTH - 1);
    assign xfer    = Valid_OUT && Ready_IN;
    assign last_rd = rd_cnt == AW'(DEPTH - 1);
    assign Out     = Valid_OUT ? mem[rd_addr] : '0;

    always_ff @(posedge CLK)
        if (take) mem[wr_addr] <= In;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= FILL;
            wr_addr    <= '0;
            rd_cnt     <= '0;
            Valid_OUT  <= 1'b0;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            if (Valid_IN && state == DRAIN) Overflow <= 1'b1;
            if (state == FILL) begin
                if (take) begin
                    wr_addr <= last_wr ? '0 : wr_addr + 1'b1;
                    if (last_wr) begin
                        state      <= DRAIN;
                        Frame_Done <= 1'b1;
                        Valid_OUT  <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
            end else if (xfer) begin
                rd_cnt <= last_rd ? '0 : rd_cnt + 1'b1;
                if (last_rd) begin
                    state     <= FILL;
                    Valid_OUT <= 1'b0;
                    Busy      <= 1'b0;
                end
            end
        end
    end

`ifdef COLLECTOR_TRANSPOSE_EN
    // Walk down a column by adding OUT_W; a new column restarts at its index.
    logic [AW-1:0] row, col;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            row     <= '0;
            col     <= '0;
            rd_addr <= '0;
        end else if (xfer) begin
            if (last_rd) begin
                row     <= '0;
                col     <= '0;
                rd_addr <= '0;
            end else if (row == AW'(OUT_H - 1)) begin
                row     <= '0;
                col     <= col + 1'b1;
                rd_addr <= col + 1'b1;
            end else begin
                row     <= row + 1'b1;
                rd_addr <= rd_addr + AW'(OUT_W);
            end
        end
    end
`else
    assign rd_addr = rd_cnt;
`endif
endmodule

// File: tb/tb_conv_output_collector.sv
// tb_conv_output_collector: three collectors (5x5/s1, 5x5/s2, 1x1) on a shared stream vs a frame-level model.
module tb_conv_output_collector;
    logic        clk, clr, vin, rdy;
    logic [15:0] din;
    logic [15:0] dout [3];
    logic        vo [3], fd [3], busy [3], ovf [3];

    int passed = 0, total = 0;
    bit checking = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_output_collector #(
            .IMG_Width (g == 2 ? 1 : 5),
            .IMG_Height(g == 2 ? 1 : 5),
            .Datawidth (16),
            .Stride    (g == 1 ? 2 : 1)
        ) dut (
            .CLK(clk), .CLR(clr), .In(din), .Valid_IN(vin), .Ready_IN(rdy),
            .Out(dout[g]), .Valid_OUT(vo[g]), .Frame_Done(fd[g]), .Busy(busy[g]), .Overflow(ovf[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int side(int k);
        return k == 2 ? 1 : (k == 1 ? 3 : 5);
    endfunction

    function automatic int order(int k, int n);
`ifdef COLLECTOR_TRANSPOSE_EN
        return (n % side(k)) * side(k) + n / side(k);
`else
        return n;
`endif
    endfunction

    // Frame-level model: a store, a fill count and a drain index per instance.
    logic [15:0] store [3][25];
    int  n_wr [3], n_rd [3];
    bit  m_drain [3], m_fd [3], m_ovf [3];

    always @(posedge clk or negedge clr) begin
        for (int k = 0; k < 3; k++) begin
            if (!clr) begin
                n_wr[k] = 0; n_rd[k] = 0; m_drain[k] = 0; m_fd[k] = 0; m_ovf[k] = 0;
            end else begin
                m_fd[k] = 0;
                if (!m_drain[k]) begin
                    if (vin) begin
                        store[k][n_wr[k]] = din;
                        n_wr[k]++;
                        if (n_wr[k] == side(k) * side(k)) begin
                            n_wr[k] = 0; n_rd[k] = 0; m_drain[k] = 1; m_fd[k] = 1;
                        end
                    end
                end else begin
                    if (vin) m_ovf[k] = 1;
                    if (rdy) begin
                        n_rd[k]++;
                        if (n_rd[k] == side(k) * side(k)) begin
                            n_rd[k] = 0; m_drain[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
    endtask

    always @(negedge clk) if (checking) begin
        for (int k = 0; k < 3; k++) begin
            check("valid_out", k, 32'(vo[k]), 32'(m_drain[k]));
            check("busy", k, 32'(busy[k]), 32'(m_drain[k]));
            check("frame_done", k, 32'(fd[k]), 32'(m_fd[k]));
            check("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
            check("out", k, 32'(dout[k]), m_drain[k] ? 32'(store[k][order(k, n_rd[k])]) : 32'd0);
        end
    end

    task automatic feed(input int base);
        for (int i = 0; i < 25; i++) begin
            vin = 1;
            din = 16'(base + i);
            @(negedge clk);
        end
        vin = 0;
        check("pin_frame_done", 0, 32'(fd[0]), 1);
        check("pin_first_out", 0, 32'(dout[0]), 32'(base));
    endtask

    initial begin
        int cnt, last, xf;
        clr = 1; vin = 0; din = 0; rdy = 1;
        #2 clr = 0;
        #1;
        check("pin_reset_vo", 0, 32'(vo[0]), 0);
        check("pin_reset_out", 0, 32'(dout[0]), 0);
        checking = 1;
        repeat (3) @(negedge clk);
        clr = 1;
        // back-to-back frame, full-rate drain
        feed(1);
        cnt = 0; last = 0;
        for (int j = 0; j < 30; j++) begin
            if (vo[0]) begin cnt++; last = int'(dout[0]); end
            @(negedge clk);
        end
        check("pin_drain_len", 0, 32'(cnt), 25);
        check("pin_last_out", 0, 32'(last), 25);
        // backpressure at the fourth word
        feed(101);
        repeat (3) @(negedge clk);
        rdy = 0;
        repeat (3) begin
`ifdef COLLECTOR_TRANSPOSE_EN
            check("pin_stall_out", 0, 32'(dout[0]), 116);
`else
            check("pin_stall_out", 0, 32'(dout[0]), 104);
`endif
            check("pin_stall_vo", 0, 32'(vo[0]), 1);
            @(negedge clk);
        end
        rdy = 1;
        xf = 3;
        for (int j = 0; j < 40; j++) begin
            if (vo[0] && rdy) xf++;
            @(negedge clk);
        end
        check("pin_xfers", 0, 32'(xf), 25);
        // overflow mid-drain, then reset mid-drain
        feed(201);
        repeat (2) @(negedge clk);
        check("pin_ovf_before", 0, 32'(ovf[0]), 0);
        vin = 1; din = 99;
        @(negedge clk);
        vin = 0;
        check("pin_ovf_set", 0, 32'(ovf[0]), 1);
        @(negedge clk);
        check("pin_ovf_sticky", 0, 32'(ovf[0]), 1);
        #2 clr = 0;
        #1;
        check("pin_clr_vo", 0, 32'(vo[0]), 0);
        check("pin_clr_busy", 0, 32'(busy[0]), 0);
        check("pin_clr_ovf", 0, 32'(ovf[0]), 0);
        check("pin_clr_out", 0, 32'(dout[0]), 0);
        @(negedge clk);
        clr = 1;
        feed(301);
        repeat (30) @(negedge clk);
        // single-pixel frame
        vin = 1; din = 7;
        @(negedge clk);
        vin = 0;
        check("pin_d1_fd", 2, 32'(fd[2]), 1);
        check("pin_d1_vo", 2, 32'(vo[2]), 1);
        check("pin_d1_out", 2, 32'(dout[2]), 7);
        @(negedge clk);
        check("pin_d1_fill", 2, 32'(vo[2]), 0);
        // random traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            vin = $urandom_range(1, 0) == 1;
            din = 16'($urandom);
            rdy = $urandom_range(3, 0) != 0;
            if ($urandom_range(399, 0) == 0) begin
                #2 clr = 0;
                @(negedge clk);
                clr = 1;
            end else @(negedge clk);
        end
        checking = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
